demux_dispatcher: RTL and testbench
===================================

Name: demux_dispatcher

Overview:
Sequential front-end that sits directly upstream of the 1-to-4 demultiplexer (demux1to4) and drives its `in` and `sel` inputs. It accepts single-bit items over a valid/ready handshake. Each accepted bit is steered to a channel, chosen round-robin or by an explicit request, and held stable for a programmable dwell time. A programmable idle gap with the data line forced low follows each dwell. This gives the downstream demux clean, glitch-free, time-sliced selection.

Parameters:
- DWELL, 4: cycles each accepted bit is presented on demux_in. Legal range 1..255.
- GAP, 1: cycles demux_in is forced 0 after each dwell, before the next accept. Legal range 0..255.
- START_SEL, 0: reset value of demux_sel and of the round-robin pointer. Legal range 0..3.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- bit_in, input, 1: data bit offered upstream. Ignored unless bit_valid=1.
- bit_valid, input, 1: upstream has a bit to transfer.
- bit_ready, output, 1: dispatcher can accept a bit. Equals (state==IDLE).
- rr_en, input, 1: 1 selects round-robin channel choice; 0 selects chan_req. Sampled at accept.
- chan_req, input, 2: explicit channel, used when rr_en=0. Sampled at accept.
- demux_in, output, 1: registered; drives demux1to4 `in`.
- demux_sel, output, 2: registered; drives demux1to4 `sel`.
- busy, output, 1: state != IDLE.
- wrap, output, 1: registered one-cycle pulse, defined under Behaviour.

Behaviour:
- **Clock and reset:** one clock (clk); reset is synchronous and active-high.
- **Reset values** (reset sampled high at an edge, taking priority over all other inputs):
  - state=IDLE, demux_in=0, demux_sel=START_SEL, rr pointer=START_SEL;
  - both counters=0, wrap=0;
  - hence bit_ready=1, busy=0.
- **States:** IDLE, DRIVE, GAP. Internal 8-bit dwell and gap counters; 2-bit rr pointer.
- **IDLE:**
  - An accept occurs at an edge where bit_valid=1 and bit_ready=1.
  - On accept: demux_in<=bit_in; demux_sel<=(rr_en ? ptr : chan_req); dwell counter<=DWELL-1; state<=DRIVE.
  - If rr_en=1 on accept: ptr<=ptr+1 mod 4, so 3 wraps to 0.
  - If rr_en=0 on accept: ptr is unchanged.
  - With no accept: demux_in stays 0 and demux_sel holds its last value.
- **DRIVE:**
  - demux_in and demux_sel are held constant; bit_in, chan_req and rr_en are ignored.
  - While the dwell counter is nonzero, it decrements each cycle.
  - When it reaches 0: demux_in<=0 at that edge. If GAP==0, state<=IDLE. Otherwise gap counter<=GAP-1 and state<=GAP.
- **GAP:**
  - demux_in=0 and demux_sel is held, so all demux outputs are 0.
  - The gap counter decrements each cycle; at 0, state<=IDLE.
- **Latency:** an accept at edge k gives demux_in/demux_sel valid for exactly cycles k+1 .. k+DWELL.
- **Throughput:**
  - GAP>0: bit_ready is next high DWELL+GAP+1 cycles after the accept cycle.
  - GAP=0: the period is DWELL+1 cycles, and demux_in is low during the IDLE cycle.
- **wrap:** set to 1 for exactly the one cycle following an accept with rr_en=1 and ptr==3. It coincides with the first cycle of demux_sel=3. Otherwise wrap=0.
- **Handshake:**
  - bit_valid may be held high across busy periods; no transfer occurs while bit_ready=0.
  - No combinational path exists from bit_valid to bit_ready.
  - bit_valid may be deasserted without a transfer.
- **Reset mid-operation:** any in-flight bit is dropped. Outputs take reset values one edge after reset is sampled, and the next round-robin channel is START_SEL.
- **Glitch rule:** demux_sel never changes while demux_in=1.

Test Plan:
1. **Reset:** reset=1 for 2 cycles with bit_valid=1, bit_in=1 -> demux_in=0, demux_sel=0, bit_ready=1, busy=0, wrap=0; no accept occurs.
2. **Round-robin, back-to-back:** DWELL=4, GAP=1, rr_en=1, bit_valid held high, bits 1,1,1,1,1 ->
   - demux_sel 0,1,2,3,0, each with demux_in=1 for 4 cycles then 0 for 2 cycles (accept spacing 6);
   - wrap pulses exactly once, on the first cycle of sel=3;
   - demux1to4 out0..out3 go high in turn.
3. **Explicit channel:** rr_en=0, chan_req=2, bit_in=1 -> demux_sel=2, demux_in=1 for 4 cycles. Next bit then sent with rr_en=1 goes to sel=0, confirming ptr was unchanged.
4. **Backpressure and stability:** toggle bit_in and chan_req every cycle during DRIVE with bit_valid=1 -> bit_ready=0 and demux_in/demux_sel unchanged until the dwell ends; the second accept happens only in IDLE.
5. **Reset mid-DRIVE:** assert reset on the 2nd drive cycle of sel=2 -> next edge: demux_in=0, demux_sel=0, busy=0. The next rr bit goes to sel=0.
6. **GAP=0, DWELL=1:** stream 3 bits -> each bit is high for 1 cycle with accept spacing 2 cycles, and demux_in=0 in each IDLE cycle.

Source files
------------

// File: rtl/demux_dispatcher_if.sv
// Handshake and demux-drive bundle between an upstream bit source and the
// dispatcher. The master side offers bits; the slave side (dispatcher) accepts
// them and drives the downstream demux1to4 select/data lines.
interface demux_dispatcher_if;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       rr_en;
  logic [1:0] chan_req;
  logic       demux_in;
  logic [1:0] demux_sel;
  logic       busy;
  logic       wrap;

  modport master (
    output bit_in, bit_valid, rr_en, chan_req,
    input  bit_ready, demux_in, demux_sel, busy, wrap
  );

  modport slave (
    input  bit_in, bit_valid, rr_en, chan_req,
    output bit_ready, demux_in, demux_sel, busy, wrap
  );
endinterface

// File: rtl/demux_dispatcher.sv
// Front-end for demux1to4: accepts one bit at a time over valid/ready, steers
// it to a channel (round-robin or explicit), holds it for DWELL cycles, then
// forces the data line low for GAP cycles before accepting the next bit.
// demux_sel only ever changes on an accept, when demux_in was 0 the cycle
// before, so the downstream demux never sees a select change under a high bit.
module demux_dispatcher #(
  parameter int DWELL     = 4,
  parameter int GAP       = 1,
  parameter int START_SEL = 0
) (
  input  logic              clk,
  input  logic              reset,
  demux_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);
  // Only used when GAP is nonzero; with GAP==0 the gap state is skipped.
  localparam logic [7:0] GAP_LOAD   = 8'(GAP - 1);
  localparam logic [1:0] SEL_INIT   = 2'(START_SEL);
  localparam bit         GAP_EN     = (GAP != 0);

  state_t     state_reg, state_next;
  logic       din_reg, din_next;
  logic [1:0] sel_reg, sel_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [7:0] dwell_reg, dwell_next;
  logic [7:0] gap_reg, gap_next;
  logic       wrap_reg, wrap_next;

  // State and datapath registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      din_reg   <= 1'b0;
      sel_reg   <= SEL_INIT;
      ptr_reg   <= SEL_INIT;
      dwell_reg <= 8'd0;
      gap_reg   <= 8'd0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      din_reg   <= din_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      dwell_reg <= dwell_next;
      gap_reg   <= gap_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Next-state and next-output logic for the IDLE -> DRIVE -> GAP sequence.
  always_comb begin
    state_next = state_reg;
    din_next   = din_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    dwell_next = dwell_reg;
    gap_next   = gap_reg;
    wrap_next  = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        din_next = 1'b0;
        if (bus.bit_valid) begin
          din_next   = bus.bit_in;
          sel_next   = bus.rr_en ? ptr_reg : bus.chan_req;
          dwell_next = DWELL_LOAD;
          state_next = ST_DRIVE;
          if (bus.rr_en) begin
            ptr_next  = ptr_reg + 2'd1;
            wrap_next = (ptr_reg == 2'd3);
          end
        end
      end
      ST_DRIVE: begin
        if (dwell_reg != 8'd0) begin
          dwell_next = dwell_reg - 8'd1;
        end else begin
          din_next = 1'b0;
          if (GAP_EN) begin
            gap_next   = GAP_LOAD;
            state_next = ST_GAP;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_reg != 8'd0) begin
          gap_next = gap_reg - 8'd1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        din_next   = 1'b0;
      end
    endcase
  end

  assign bus.bit_ready = (state_reg == ST_IDLE);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.demux_in  = din_reg;
  assign bus.demux_sel = sel_reg;
  assign bus.wrap      = wrap_reg;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Bench for demux_dispatcher: a table of transactions drives instance A
// (DWELL=4, GAP=1) while a monitor pops expected results from a scoreboard
// at each accept and follows the dwell/gap window cycle by cycle. Instance B
// (DWELL=1, GAP=0) is exercised by a hand-written streaming sequence.
module tb_demux_dispatcher;

  localparam int A_DWELL = 4;
  localparam int A_GAP   = 1;
  localparam int A_RUN   = A_DWELL + A_GAP;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  demux_dispatcher_if a ();
  demux_dispatcher_if b ();

  demux_dispatcher #(.DWELL(A_DWELL), .GAP(A_GAP), .START_SEL(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a)
  );

  demux_dispatcher #(.DWELL(1), .GAP(0), .START_SEL(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pre_rst;
    logic       mid_rst;
    logic       toggle;
    logic       bit_v;
    logic       rr;
    logic [1:0] req;
    logic [1:0] exp_sel;
    logic       exp_wrap;
  } vec_t;

  typedef struct {
    logic       b;
    logic [1:0] sel;
    logic       w;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pre_rst, input logic mid_rst, input logic toggle,
                              input logic bit_v, input logic rr, input logic [1:0] req,
                              input logic [1:0] exp_sel, input logic exp_wrap);
    vec_t v;
    v.pre_rst = pre_rst; v.mid_rst = mid_rst; v.toggle = toggle;
    v.bit_v = bit_v; v.rr = rr; v.req = req;
    v.exp_sel = exp_sel; v.exp_wrap = exp_wrap;
    return v;
  endfunction

  // ---------------- monitor / scoreboard for instance A ----------------
  logic rst_e;
  logic acc_e;
  int   run = -1;
  exp_t cur;

  always @(posedge clk) begin
    rst_e = reset;
    acc_e = a.bit_valid && a.bit_ready;
    #1;
    if (rst_e) begin
      run = -1;
      sb.delete();
      chk("rst_in", int'(a.demux_in), 0);
      chk("rst_sel", int'(a.demux_sel), 0);
      chk("rst_ready", int'(a.bit_ready), 1);
      chk("rst_busy", int'(a.busy), 0);
      chk("rst_wrap", int'(a.wrap), 0);
    end else if (acc_e) begin
      if (sb.size() == 0) begin
        chk("unexpected_accept", 1, 0);
        cur.b = 1'b0; cur.sel = 2'd0; cur.w = 1'b0;
      end else begin
        cur = sb.pop_front();
      end
      run = 0;
      $display("accept: bit=%0d sel=%0d wrap=%0d (expected bit=%0d sel=%0d wrap=%0d)",
               a.demux_in, a.demux_sel, a.wrap, cur.b, cur.sel, cur.w);
      chk("acc_in", int'(a.demux_in), int'(cur.b));
      chk("acc_sel", int'(a.demux_sel), int'(cur.sel));
      chk("acc_wrap", int'(a.wrap), int'(cur.w));
      chk("acc_busy", int'(a.busy), 1);
      chk("acc_ready", int'(a.bit_ready), 0);
    end else if (run >= 0) begin
      run++;
      if (run < A_RUN) begin
        chk("hold_sel", int'(a.demux_sel), int'(cur.sel));
        chk("hold_in", int'(a.demux_in), (run < A_DWELL) ? int'(cur.b) : 0);
        chk("hold_wrap", int'(a.wrap), 0);
        chk("hold_busy", int'(a.busy), 1);
      end else begin
        chk("end_ready", int'(a.bit_ready), 1);
        chk("end_in", int'(a.demux_in), 0);
        chk("end_sel", int'(a.demux_sel), int'(cur.sel));
        run = -1;
      end
    end else begin
      chk("idle_in", int'(a.demux_in), 0);
      chk("idle_busy", int'(a.busy), 0);
      chk("idle_wrap", int'(a.wrap), 0);
    end
  end

  // Holds reset high for n cycles while a bit is offered; no accept may happen.
  task automatic do_reset(input int n);
    reset = 1'b1;
    a.bit_valid = 1'b1;
    a.bit_in = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    a.bit_valid = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int   n;
    exp_t e;

    reset = 1'b1;
    a.bit_in = 1'b0; a.bit_valid = 1'b0; a.rr_en = 1'b0; a.chan_req = 2'd0;
    b.bit_in = 1'b0; b.bit_valid = 1'b0; b.rr_en = 1'b0; b.chan_req = 2'd0;

    //               pre mid tgl bit rr req sel wrap
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 2, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 3, 3, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 2, 1, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_rst) do_reset(2);
      n = 0;
      while (!a.bit_ready && n < 50) begin
        if (vecs[i].toggle) begin
          a.bit_in = ~a.bit_in;
          a.chan_req = a.chan_req + 2'd1;
        end
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("ready_timeout", 0, 1);
      a.bit_in = vecs[i].bit_v;
      a.rr_en = vecs[i].rr;
      a.chan_req = vecs[i].req;
      a.bit_valid = 1'b1;
      e.b = vecs[i].bit_v; e.sel = vecs[i].exp_sel; e.w = vecs[i].exp_wrap;
      sb.push_back(e);
      @(negedge clk);
      if (vecs[i].mid_rst) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        a.bit_valid = 1'b0;
      end
    end
    a.bit_valid = 1'b0;
    repeat (A_RUN + 3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // GAP=0, DWELL=1 streaming on instance B: high for one cycle, low in IDLE.
    b.bit_in = 1'b1;
    b.rr_en = 1'b1;
    b.bit_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      $display("b bit %0d drive: in=%0d sel=%0d busy=%0d", j, b.demux_in, b.demux_sel, b.busy);
      chk("b_drive_in", int'(b.demux_in), 1);
      chk("b_drive_sel", int'(b.demux_sel), j);
      chk("b_drive_ready", int'(b.bit_ready), 0);
      chk("b_wrap", int'(b.wrap), 0);
      @(negedge clk);
      $display("b bit %0d idle: in=%0d sel=%0d ready=%0d", j, b.demux_in, b.demux_sel, b.bit_ready);
      chk("b_idle_in", int'(b.demux_in), 0);
      chk("b_idle_sel", int'(b.demux_sel), j);
      chk("b_idle_ready", int'(b.bit_ready), 1);
    end
    b.bit_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_quiet_busy", int'(b.busy), 0);
    chk("b_quiet_in", int'(b.demux_in), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
